// File: rtl/axis_frame_len_queue.sv
// Tags frame-length strobes under/oversize and queues them to an AXI-Stream output, one cycle from strobe to tvalid.
// The strobe source is never stalled: a strobe that arrives while the queue is full and not being popped is dropped and counted.
module axis_frame_len_queue #(
  parameter int LEN_WIDTH = 16,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 32,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LEN_WIDTH-1:0]     frame_len,
  input  logic                     frame_len_valid,
  output logic [LEN_WIDTH-1:0]     m_axis_len_tdata,
  output logic [1:0]               m_axis_len_tuser,
  output logic                     m_axis_len_tvalid,
  input  logic                     m_axis_len_tready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_WIDTH-1:0]     frame_count,
  output logic [CNT_WIDTH-1:0]     drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [LEN_WIDTH-1:0] MIN_L   = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_L   = LEN_WIDTH'(MAX_LEN);
  localparam logic [FW-1:0]        FULL_LVL = FW'(DEPTH);

  typedef struct packed {
    logic [1:0]           tag;
    logic [LEN_WIDTH-1:0] len;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            pop;
  logic            push;
  logic            drop;
  logic            full;

  // A full queue still takes a strobe when the head leaves in the same cycle.
  assign full  = (fill_level == FULL_LVL);
  assign pop   = m_axis_len_tvalid && m_axis_len_tready;
  assign push  = frame_len_valid && (!full || pop);
  assign drop  = frame_len_valid && !push;

  assign wr_entry.tag = {frame_len > MAX_L, frame_len < MIN_L};
  assign wr_entry.len = frame_len;

  assign m_axis_len_tvalid = (fill_level != '0);
  assign m_axis_len_tdata  = mem[rd_ptr].len;
  assign m_axis_len_tuser  = mem[rd_ptr].tag;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fill_level  <= '0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fill_level <= fill_level + FW'(1);
        2'b01:   fill_level <= fill_level - FW'(1);
        default: fill_level <= fill_level;
      endcase
      // Counters saturate at all-ones rather than wrapping.
      if (push && (frame_count != '1)) begin
        frame_count <= frame_count + CNT_WIDTH'(1);
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_len_queue.sv
// Bench for axis_frame_len_queue: directed and random traffic against a queue-based reference model.
module tb_axis_frame_len_queue;

  localparam int LW   = 16;
  localparam int D    = 16;
  localparam int CW   = 32;
  localparam int MINL = 64;
  localparam int MAXL = 1518;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [LW-1:0]     frame_len = '0;
  logic              frame_len_valid = 1'b0;
  logic [LW-1:0]     tdata;
  logic [1:0]        tuser;
  logic              tvalid;
  logic              tready = 1'b0;
  logic [$clog2(D):0] fill_level;
  logic [CW-1:0]     frame_count;
  logic [CW-1:0]     drop_count;

  axis_frame_len_queue #(
    .LEN_WIDTH(LW), .DEPTH(D), .CNT_WIDTH(CW), .MIN_LEN(MINL), .MAX_LEN(MAXL)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_len         (frame_len),
    .frame_len_valid   (frame_len_valid),
    .m_axis_len_tdata  (tdata),
    .m_axis_len_tuser  (tuser),
    .m_axis_len_tvalid (tvalid),
    .m_axis_len_tready (tready),
    .fill_level        (fill_level),
    .frame_count       (frame_count),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of {tag, len} plus plain event counts.
  logic [LW+1:0] mq[$];
  logic [LW+1:0] popped[$];
  int m_frames = 0;
  int m_drops  = 0;

  function automatic logic [1:0] tag_of(input int len);
    logic [1:0] t;
    t[0] = (len < MINL);
    t[1] = (len > MAXL);
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("tvalid", 64'(tvalid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("tdata", 64'(tdata), 64'(mq[0][LW-1:0]));
      chk("tuser", 64'(tuser), 64'(mq[0][LW+1:LW]));
    end
    chk("fill_level", 64'(fill_level), 64'(mq.size()));
    chk("frame_count", 64'(frame_count), 64'(m_frames));
    chk("drop_count", 64'(drop_count), 64'(m_drops));
  endtask

  // Called at a falling edge: drive inputs, check, advance one clock, update model.
  task automatic step(input logic v, input int len, input logic r);
    logic was_full;
    logic did_pop;
    frame_len_valid = v;
    frame_len       = LW'(len);
    tready          = r;
    check_state();
    @(posedge clk);
    was_full = (mq.size() == D);
    did_pop  = (mq.size() != 0) && r;
    if (did_pop) popped.push_back(mq.pop_front());
    if (v) begin
      if (!was_full || did_pop) begin
        mq.push_back({tag_of(len), LW'(len)});
        m_frames++;
      end else begin
        m_drops++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int base;
    int lens [5];
    logic [1:0] exp_tag [5];
    int f0;
    int d0;

    lens    = '{40, 1600, 64, 1518, 0};
    exp_tag = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_frames", 64'(frame_count), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single push
    step(1'b1, 100, 1'b1);
    chk("single_tvalid", 64'(tvalid), 64'd1);
    chk("single_tdata", 64'(tdata), 64'd100);
    chk("single_tuser", 64'(tuser), 64'd0);
    step(1'b0, 0, 1'b1);
    chk("single_popped", 64'(popped[popped.size()-1][LW-1:0]), 64'd100);
    chk("single_fill", 64'(fill_level), 64'd0);
    chk("single_frames", 64'(frame_count), 64'd1);

    // Tagging boundaries
    base = popped.size();
    for (int i = 0; i < 5; i++) step(1'b1, lens[i], 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("tag_len", 64'(popped[base+i][LW-1:0]), 64'(lens[i]));
      chk("tag_bits", 64'(popped[base+i][LW+1:LW]), 64'(exp_tag[i]));
    end

    // Overfill with tready low
    f0 = m_frames;
    d0 = m_drops;
    for (int i = 0; i < 20; i++) step(1'b1, 200 + i, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("full_fill", 64'(fill_level), 64'd16);
    chk("full_frames", 64'(frame_count), 64'(f0 + 16));
    chk("full_drops", 64'(drop_count), 64'(d0 + 4));

    // Push into a full queue while popping
    base = popped.size();
    step(1'b1, 777, 1'b1);
    chk("fullpop_fill", 64'(fill_level), 64'd16);
    chk("fullpop_drops", 64'(drop_count), 64'(d0 + 4));
    repeat (16) step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    for (int i = 0; i < 16; i++) chk("drain_order", 64'(popped[base+i][LW-1:0]), 64'(200 + i));
    chk("drain_last", 64'(popped[base+16][LW-1:0]), 64'd777);

    // Random traffic across several pointer wraps
    for (int i = 0; i < 6 * D; i++) begin
      int len;
      case ($urandom_range(0, 5))
        0:       len = 63;
        1:       len = 64;
        2:       len = 1518;
        3:       len = 1519;
        default: len = int'($urandom_range(0, 65535));
      endcase
      step(($urandom_range(0, 3) != 0), len, ($urandom_range(0, 1) == 1));
    end
    while (mq.size() != 0) step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);

    // Asynchronous reset with entries queued
    for (int i = 0; i < 5; i++) step(1'b1, 300 + i, 1'b0);
    chk("prerst_fill", 64'(fill_level), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 64'(tvalid), 64'd0);
    chk("arst_fill", 64'(fill_level), 64'd0);
    chk("arst_frames", 64'(frame_count), 64'd0);
    chk("arst_drops", 64'(drop_count), 64'd0);
    mq.delete();
    m_frames = 0;
    m_drops  = 0;
    frame_len_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 200, 1'b0);
    chk("postrst_tdata", 64'(tdata), 64'd200);
    chk("postrst_frames", 64'(frame_count), 64'd1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
